uart_tx_drain: RTL and testbench
================================

# uart_tx_drain

Serial transmit stage that sits directly downstream of the CPLD circular byte buffer. Whenever the buffer reports a non-zero fill level, the block pops one byte with a single-cycle read strobe and shifts it out as an 8N1 UART frame. It then returns to polling. It is the buffer's only consumer and the only driver of the board's TX pin.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: system clock in Hz.
- `BAUD_RATE`, 115200: line rate in baud. `BAUD_DIV = CLK_FREQ / BAUD_RATE` (integer division, must be ≥ 2).
- `DATA_WIDTH`, 8: frame data bits. Must match the buffer's data width.
- `ADDRESS_WIDTH`, 8: width of the buffer fill-level port.

Ports:
- `i_clk`, in, 1: the single system clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_tx_en`, in, 1: when low, no new frame is started. A frame already in flight always completes.
- `i_data_size`, in, `ADDRESS_WIDTH`: buffer fill level.
- `i_data`, in, `DATA_WIDTH`: buffer head byte (combinational from the buffer).
- `o_read_en`, out, 1: one-cycle pop strobe to the buffer.
- `o_tx`, out, 1: serial line, idle high.
- `o_busy`, out, 1: high whenever the FSM is not in IDLE.
- `o_frame_done`, out, 1: one-cycle pulse when the stop bit finishes.

## Operation
FSM states: IDLE, START, DATA, STOP. All outputs are registered.

- **IDLE.** `o_tx`=1. If `i_tx_en` && `i_data_size != 0` at a clock edge:
  - capture `i_data` into the shift register;
  - set `o_read_en`=1 and `o_tx`=0;
  - clear the baud counter and bit counter;
  - go to START.
- **START.** `o_read_en` is cleared after one cycle. When the baud counter reaches `BAUD_DIV-1`:
  - drive shift register bit 0 on `o_tx`;
  - go to DATA.
- **DATA.** On each baud-counter terminal count:
  - shift right (LSB first);
  - increment the bit counter;
  - after bit `DATA_WIDTH-1`, drive `o_tx`=1 and go to STOP.
- **STOP.** On terminal count:
  - pulse `o_frame_done`;
  - go to IDLE.
- **Baud counter.** Width is `u_log2(BAUD_DIV)`. It wraps to 0 at `BAUD_DIV-1` and runs only outside IDLE.
- **Fill level while busy.** `i_data_size` is ignored outside IDLE. The buffer's decrement caused by the pop is therefore never double-counted.
- **Empty buffer.** The FSM stays in IDLE with `o_tx` high and never strobes.
- **Full buffer.** No special handling. The block drains at line rate, and any overrun is the buffer's concern.
- **`i_tx_en` deasserted mid-frame.** No effect until the frame returns to IDLE.
- **Reset (any time, including mid-frame).** Immediately forces:
  - state IDLE;
  - `o_tx`=1, `o_read_en`=0, `o_busy`=0, `o_frame_done`=0;
  - all counters and the shift register to 0.
  
  A truncated frame is not resumed.

## Timing
- **Pop latency.** Let edge k be the edge at which IDLE sees a non-empty buffer with `i_tx_en` high. Then `o_read_en` and `o_busy` go high and `o_tx` falls, all at edge k. `o_read_en` drops at edge k+1, the same edge the buffer advances its read index. Exactly one pop occurs per frame.
- **Frame length.**
  - The start bit occupies `BAUD_DIV` cycles starting at edge k.
  - Each data bit occupies `BAUD_DIV` cycles.
  - The stop bit occupies `BAUD_DIV` cycles.
  - The total is `(DATA_WIDTH+2)*BAUD_DIV` cycles.
- **End of frame.** `o_frame_done` is high for the one cycle after the stop bit ends; `o_busy` falls at that same edge.
- **Back-to-back frames.** The next start bit begins no earlier than 1 clock after the stop bit ends. This 1-cycle IDLE gap extends the stop bit and is legal 8N1.

## Structure
- **Shared header.** `u_log2` comes from the existing `utils.vh` include. FSM state encodings (2-bit localparams) also go there, so a future `uart_rx_fill` can reuse them.
- **Sub-module.** One sub-module is natural: `baud_tick_gen`, holding the `BAUD_DIV` counter with an enable input and a terminal-count tick output. It is reusable by the RX side.
- **Top-level logic.** The FSM, shift register and bit counter stay in `uart_tx_drain`.

## Test plan
Simulation uses `CLK_FREQ`=80 and `BAUD_RATE`=10, so `BAUD_DIV`=8.

1. **Reset values.** Assert `i_rst_n`=0 with `i_data_size`=3 → `o_tx`=1 and `o_read_en`=0 throughout reset. After release, the first pop occurs exactly 1 edge later.
2. **Single byte.** Single byte 0x55, `i_data_size` 1→0 after the pop:
   - `o_read_en` high for exactly 1 cycle;
   - `o_tx` sequence 0,1,0,1,0,1,0,1,0,1, each level 8 cycles;
   - `o_frame_done` pulses at cycle 80;
   - `o_busy` is then low.
3. **Back-to-back.** Buffer holds 0xA3, 0x0F:
   - two pops, 81 cycles apart;
   - decoded bytes are 0xA3 then 0x0F;
   - exactly one idle-high cycle between the two stop and start bits.
4. **Empty buffer.** `i_data_size`=0 for 1000 cycles → no `o_read_en`, `o_tx` constantly 1, `o_busy`=0.
5. **`i_tx_en` gating.** Drop `i_tx_en` at cycle 20 of a frame with 2 bytes queued:
   - the current frame completes intact;
   - no second pop occurs until `i_tx_en` returns high;
   - the pop then follows on the next edge.
6. **Mid-frame reset.** Assert reset during data bit 3 → `o_tx` goes to 1 asynchronously, and the FSM is in IDLE. After release, a fresh frame starts with a start bit, and no partial data is emitted.

Source files
------------

// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the UART drain/fill pair: FSM state encoding and a sizing helper.
package uart_tx_drain_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned u_log2(input int unsigned value);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_drain_baud_tick_gen.sv
// Baud-rate divider: counts BAUD_DIV cycles while enabled and flags the terminal count.
module baud_tick_gen
  import uart_tx_drain_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CNT_W = u_log2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_tick = i_en && (cnt_q == LAST_CNT);

  // Held at zero while disabled so every frame starts from a clean count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (!i_en || o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the circular buffer whenever it is non-empty and sends them as 8N1 frames.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_tx_en,
  input  logic [ADDRESS_WIDTH-1:0] i_data_size,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_read_en,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BIT_CNT_W = u_log2(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_e               state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic                    baud_tick;

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (state_q != StIdle),
    .o_tick  (baud_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      o_tx         <= 1'b1;
      o_read_en    <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_read_en    <= 1'b0;
      o_frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Fill level is only looked at here, so the pop's own decrement is never re-read.
          if (i_tx_en && (i_data_size != '0)) begin
            shift_q   <= i_data;
            bit_cnt_q <= '0;
            o_read_en <= 1'b1;
            o_tx      <= 1'b0;
            o_busy    <= 1'b1;
            state_q   <= StStart;
          end else begin
            o_tx <= 1'b1;
          end
        end
        StStart: begin
          if (baud_tick) begin
            o_tx    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (baud_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
              o_tx    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              o_tx      <= shift_q[1];
            end
          end
        end
        StStop: begin
          if (baud_tick) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: a queue-based buffer model feeds the DUT, frames are checked bit-by-bit.
module tb_uart_tx_drain;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DIV   = 8;
  localparam int unsigned FRAME = (DW + 2) * DIV;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_tx_en = 1'b0;
  logic [AW-1:0] i_data_size = '0;
  logic [DW-1:0] i_data = '0;
  logic          o_read_en;
  logic          o_tx;
  logic          o_busy;
  logic          o_frame_done;

  logic [DW-1:0] buf_q[$];
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  uart_tx_drain #(
    .CLK_FREQ      (80),
    .BAUD_RATE     (10),
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tx_en      (i_tx_en),
    .i_data_size  (i_data_size),
    .i_data       (i_data),
    .o_read_en    (o_read_en),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  // Buffer model: the read index advances on the edge that sees the strobe.
  always @(posedge i_clk) begin
    if (o_read_en && buf_q.size() != 0) void'(buf_q.pop_front());
  end

  always @(negedge i_clk) begin
    i_data_size = AW'(buf_q.size());
    i_data      = (buf_q.size() != 0) ? buf_q[0] : '0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    buf_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_pop(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge i_clk);
      waited++;
    end while (!o_read_en && waited < budget);
    check_eq("pop_seen", 32'(o_read_en), 32'd1);
  endtask

  // Called at the negedge just after the pop edge; walks the whole frame and the cycle after.
  task automatic expect_frame(input int drop_at);
    logic [DW-1:0] b;
    logic [DW+1:0] frame;
    int tx_err = 0;
    int re_cnt = 0;
    int busy_err = 0;
    int done_err = 0;
    b     = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    frame = {1'b1, b, 1'b0};
    for (int c = 0; c < int'(FRAME); c++) begin
      if (c > 0) @(negedge i_clk);
      if (c == drop_at) i_tx_en = 1'b0;
      if (o_tx !== frame[c / DIV]) tx_err++;
      if (o_read_en === 1'b1) re_cnt++;
      if (o_busy !== 1'b1) busy_err++;
      if (o_frame_done !== 1'b0) done_err++;
    end
    @(negedge i_clk);
    check_eq("frame_bits", tx_err, 0);
    check_eq("read_en_width", re_cnt, 1);
    check_eq("busy_in_frame", busy_err, 0);
    check_eq("done_early", done_err, 0);
    check_eq("frame_done", 32'(o_frame_done), 32'd1);
    check_eq("busy_after", 32'(o_busy), 32'd0);
    check_eq("tx_after", 32'(o_tx), 32'd1);
  endtask

  initial begin
    int w;
    int cnt;
    logic [DW-1:0] b;

    // Reset with a non-empty buffer, then three back-to-back frames.
    i_rst_n = 1'b0;
    i_tx_en = 1'b1;
    for (int i = 0; i < 3; i++) push(DW'($urandom));
    cnt = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1 || o_read_en !== 1'b0 || o_busy !== 1'b0) cnt++;
    end
    check_eq("reset_outputs", cnt, 0);
    i_rst_n = 1'b1;
    wait_pop(4, w);
    check_eq("pop_after_reset", w, 1);
    expect_frame(-1);
    for (int i = 0; i < 2; i++) begin
      wait_pop(4, w);
      check_eq("b2b_gap", w, 1);
      expect_frame(-1);
    end

    // Single 0x55.
    push(8'h55);
    wait_pop(5, w);
    expect_frame(-1);

    // 0xA3 then 0x0F, 81 cycles apart.
    push(8'hA3);
    push(8'h0F);
    wait_pop(5, w);
    expect_frame(-1);
    wait_pop(4, w);
    check_eq("pop_spacing", w, 1);
    expect_frame(-1);

    // Empty buffer.
    cnt = 0;
    repeat (1000) begin
      @(negedge i_clk);
      if (o_read_en !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) cnt++;
    end
    check_eq("empty_idle", cnt, 0);

    // tx_en dropped mid-frame with a second byte queued.
    push(DW'($urandom));
    push(DW'($urandom));
    wait_pop(5, w);
    expect_frame(20);
    cnt = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_read_en !== 1'b0 || o_busy !== 1'b0) cnt++;
    end
    check_eq("gated_no_pop", cnt, 0);
    i_tx_en = 1'b1;
    wait_pop(4, w);
    check_eq("pop_after_enable", w, 1);
    expect_frame(-1);

    // Reset during data bit 3 (chosen as 0 so the async rise is visible).
    b = DW'($urandom) & 8'hF7;
    push(b);
    wait_pop(5, w);
    repeat (35) @(negedge i_clk);
    check_eq("pre_reset_tx", 32'(o_tx), 32'd0);
    #1 i_rst_n = 1'b0;
    #1;
    check_eq("async_reset_tx", 32'(o_tx), 32'd1);
    check_eq("async_reset_busy", 32'(o_busy), 32'd0);
    void'(exp_q.pop_front());
    push(DW'($urandom));
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_pop(4, w);
    check_eq("pop_after_midreset", w, 1);
    expect_frame(-1);

    // Random bursts with random idle gaps.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) push(DW'($urandom));
      for (int i = 0; i < n; i++) begin
        wait_pop(6, w);
        expect_frame(-1);
      end
      repeat ($urandom_range(0, 20)) @(negedge i_clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
